// File: rtl/accum_ctrl.sv
// accum_ctrl: debounced single-step controller for an add/subtract accumulator.
// A synchronized, debounced pushbutton press walks the FSM through
// CAPTURE -> EXEC -> CHECK. The datapath gets one Acc_en strobe per press.
// Count and sticky Err are tracked here. Clr overrides every transition.
module accum_ctrl #(
  parameter int N         = 8,
  parameter int DB_CYCLES = 4,
  parameter int COUNT_MAX = 15
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         KEYn,
  input  logic         Clr,
  input  logic         Sub,
  input  logic [N-1:0] Din,
  input  logic         Ovf_in,
  output logic         Acc_en,
  output logic         Acc_sub,
  output logic [N-1:0] Operand,
  output logic         Acc_clr,
  output logic [3:0]   Count,
  output logic         Busy,
  output logic         Err
);

  localparam int          CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [3:0]  CMAX = 4'(COUNT_MAX);

  typedef enum logic [2:0] {IDLE, CAPTURE, EXEC, CHECK, HALT} state_t;

  logic          key_s1, key_s2;
  logic          armed;
  logic [CW-1:0] db_cnt;
  logic          db_hit, press;
  state_t        state, nxt;
  logic [3:0]    cnt_inc;

  // Two-flop synchronizer for the raw key. It resets to the released level.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= KEYn;
      key_s2 <= key_s1;
    end
  end

  // db_cnt counts earlier consecutive cycles at the level being waited for.
  // When armed, that level is low. When disarmed, it is high.
  assign db_hit = (db_cnt == DB_LAST);
  assign press  = armed & ~key_s2 & db_hit;

  // Debouncer. It fires once on a stable low, then waits for a stable high before re-arming.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      armed  <= 1'b1;
      db_cnt <= '0;
    end else if (armed) begin
      if (key_s2)      db_cnt <= '0;
      else if (db_hit) begin armed <= 1'b0; db_cnt <= '0; end
      else             db_cnt <= db_cnt + 1'b1;
    end else begin
      if (!key_s2)     db_cnt <= '0;
      else if (db_hit) begin armed <= 1'b1; db_cnt <= '0; end
      else             db_cnt <= db_cnt + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= nxt;
  end

  assign cnt_inc = Count + 4'd1;

  // Next-state logic. Clr wins over everything, and presses outside IDLE are dropped.
  always_comb begin
    nxt = state;
    if (Clr) nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (press) nxt = CAPTURE;
        CAPTURE: nxt = EXEC;
        EXEC:    nxt = CHECK;
        CHECK:   nxt = (Ovf_in || cnt_inc == CMAX) ? HALT : IDLE;
        HALT:    nxt = HALT;
        default: nxt = IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    Acc_en = (state == EXEC);
    Busy   = (state == CAPTURE) || (state == EXEC) || (state == CHECK);
  end

  // Operand and operation select are loaded only in CAPTURE and held otherwise
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Operand <= '0;
      Acc_sub <= 1'b0;
    end else if (state == CAPTURE) begin
      Operand <= Din;
      Acc_sub <= Sub;
    end
  end

  // Count, sticky Err, and the clear strobe echoed one cycle after Clr
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Count   <= 4'd0;
      Err     <= 1'b0;
      Acc_clr <= 1'b0;
    end else begin
      Acc_clr <= Clr;
      if (Clr) begin
        Count <= 4'd0;
        Err   <= 1'b0;
      end else if (state == CHECK) begin
        if (Ovf_in) Err   <= 1'b1;
        else        Count <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_accum_ctrl.sv
// Bench for accum_ctrl. A per-cycle behavioural model covers debouncing
// with run lengths and the operation with a phase count. A table covers a
// clean press. Directed sequences cover the corner cases, then random KEYn runs.
module tb_accum_ctrl;
  localparam int DB = 4;
  localparam int CM = 15;

  logic       Clock, Resetn, KEYn, Clr, Sub, Ovf_in;
  logic [7:0] Din;
  logic       Acc_en, Acc_sub, Acc_clr, Busy, Err;
  logic [7:0] Operand;
  logic [3:0] Count;

  accum_ctrl #(.N(8), .DB_CYCLES(DB), .COUNT_MAX(CM)) dut (
    .Clock(Clock), .Resetn(Resetn), .KEYn(KEYn), .Clr(Clr), .Sub(Sub),
    .Din(Din), .Ovf_in(Ovf_in), .Acc_en(Acc_en), .Acc_sub(Acc_sub),
    .Operand(Operand), .Acc_clr(Acc_clr), .Count(Count), .Busy(Busy), .Err(Err)
  );

  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end

  int n_cmp = 0, n_bad = 0;

  // Reference model state
  bit   m_s1, m_lvl, m_armed, m_halt, m_err, m_sub, m_clrq;
  int   m_run, m_phase, m_cnt;
  logic [7:0] m_op;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1; m_lvl = 1; m_run = 1; m_armed = 1;
    m_phase = 0; m_halt = 0; m_cnt = 0; m_err = 0;
    m_op = 0; m_sub = 0; m_clrq = 0;
  endtask

  // Advance one clock with the current inputs, then compare every output to the model
  task automatic cyc();
    bit p;
    bit nl;
    p = m_armed && !m_lvl && (m_run == DB);
    if (m_phase == 1) begin m_op = Din; m_sub = Sub; end
    m_clrq = Clr;
    if (Clr) begin
      m_phase = 0; m_halt = 0; m_cnt = 0; m_err = 0;
    end else if (!m_halt) begin
      case (m_phase)
        0: if (p) m_phase = 1;
        1: m_phase = 2;
        2: m_phase = 3;
        default: begin
          m_phase = 0;
          if (Ovf_in) begin m_err = 1; m_halt = 1; end
          else begin
            m_cnt++;
            if (m_cnt == CM) m_halt = 1;
          end
        end
      endcase
    end
    if (p) m_armed = 0;
    else if (!m_armed && m_lvl && m_run == DB) m_armed = 1;
    nl = m_s1;
    m_s1 = KEYn;
    if (nl == m_lvl) m_run = (m_run < DB + 1) ? m_run + 1 : m_run;
    else m_run = 1;
    m_lvl = nl;
    @(posedge Clock); #1;
    chk("cycle", {Acc_en, Busy, Acc_clr, Err, Count, Acc_sub, Operand},
        {(m_phase == 2), (m_phase != 0), m_clrq, m_err, 4'(m_cnt), m_sub, m_op});
  endtask

  task automatic run_key(input logic k, input int n, inout int en_cnt);
    KEYn = k;
    repeat (n) begin
      cyc();
      if (Acc_en) en_cnt++;
    end
  endtask

  // what=0: wait for CAPTURE (Busy without Acc_en); what=1: wait for EXEC
  task automatic wait_for(input int what);
    bit got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      cyc();
      got = what ? Acc_en : (Busy && !Acc_en);
    end
    chk(what ? "wait_exec" : "wait_capture", 32'(got), 32'd1);
  endtask

  typedef struct {
    logic       keyn;
    logic [7:0] din;
    logic       sub;
    logic       en;
    logic       busy;
    logic [3:0] cnt;
    logic [7:0] op;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int en;
    int seg;
    Resetn = 0; KEYn = 1; Clr = 0; Sub = 0; Din = 0; Ovf_in = 0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      tbl[i].keyn = 0; tbl[i].din = 8'h05; tbl[i].sub = 0;
      tbl[i].en = (i == 6);
      tbl[i].busy = (i >= 5 && i <= 7);
      tbl[i].cnt = (i >= 8) ? 4'd1 : 4'd0;
      tbl[i].op = (i >= 6) ? 8'h05 : 8'h00;
    end

    repeat (2) @(posedge Clock);
    #2;
    chk("reset_state", {Acc_en, Busy, Acc_clr, Err, Count, Acc_sub, Operand}, 32'd0);
    #1 Resetn = 1;

    // Clean press, checked one cycle at a time
    for (int i = 0; i < 10; i++) begin
      KEYn = tbl[i].keyn; Din = tbl[i].din; Sub = tbl[i].sub;
      cyc();
      chk($sformatf("vec%0d", i), {Acc_en, Busy, Count, Operand},
          {tbl[i].en, tbl[i].busy, tbl[i].cnt, tbl[i].op});
    end

    // Bounce, then a long hold: exactly one event, no re-arm after a short high
    en = 0;
    run_key(1, 8, en);
    run_key(0, 2, en); run_key(1, 1, en); run_key(0, 2, en); run_key(0, 20, en);
    chk("bounce_one_event", 32'(en), 32'd1);
    run_key(1, 3, en); run_key(0, 10, en);
    chk("short_high_no_rearm", 32'(en), 32'd1);
    run_key(1, 8, en);

    // Fill the counter to COUNT_MAX
    while (Count < 4'(CM) && n_cmp < 5000) begin
      Din = 8'($urandom); Sub = 1'($urandom);
      run_key(0, 8, en); run_key(1, 8, en);
    end
    chk("count_max", {Count, Busy}, {4'(CM), 1'b0});
    en = 0;
    run_key(0, 8, en); run_key(1, 8, en);
    chk("halt_ignores_press", {28'(en), Count}, {28'd0, 4'(CM)});
    Clr = 1; cyc(); Clr = 0;
    chk("clr_strobe", {Acc_clr, Count}, {1'b1, 4'd0});
    cyc();
    chk("clr_strobe_single", 32'(Acc_clr), 32'd0);

    // Overflow: sticky error, halt, presses ignored until clear
    Ovf_in = 1;
    run_key(0, 8, en); run_key(1, 8, en);
    chk("ovf_err", {Err, Count, Busy}, {1'b1, 4'd0, 1'b0});
    en = 0;
    run_key(0, 8, en); run_key(1, 8, en);
    chk("ovf_ignores_press", 32'(en), 32'd0);
    Ovf_in = 0;
    Clr = 1; cyc(); Clr = 0;
    chk("ovf_cleared", {Err, Acc_clr}, 2'b01);

    // Clr in CAPTURE prevents EXEC
    KEYn = 0;
    wait_for(0);
    Clr = 1; cyc(); Clr = 0;
    chk("clr_in_capture", {Acc_en, Busy, Acc_clr}, 3'b001);
    en = 0;
    run_key(0, 4, en);
    chk("clr_capture_no_en", 32'(en), 32'd0);
    run_key(1, 8, en);

    // Clr in EXEC: Acc_en already seen, then clear, count unchanged
    KEYn = 0;
    wait_for(1);
    Clr = 1; cyc(); Clr = 0;
    chk("clr_in_exec", {Acc_en, Busy, Acc_clr, Count}, {3'b001, 4'd0});
    run_key(1, 8, en);

    // Asynchronous reset during EXEC
    KEYn = 0;
    wait_for(1);
    #1 Resetn = 0;
    #1;
    chk("reset_in_exec", {Acc_en, Busy, Acc_clr, Err, Count, Acc_sub, Operand}, 32'd0);
    model_reset();
    KEYn = 1;
    @(posedge Clock); @(posedge Clock);
    #3 Resetn = 1;

    // Random KEYn runs with sparse Clr and overflow
    for (int s = 0; s < 400; s++) begin
      KEYn = 1'($urandom);
      seg = $urandom_range(1, 10);
      for (int c = 0; c < seg; c++) begin
        Din = 8'($urandom);
        Sub = 1'($urandom);
        Ovf_in = ($urandom_range(0, 15) == 0);
        Clr = ($urandom_range(0, 39) == 0);
        cyc();
      end
    end
    Clr = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/accum_ctrl.md
ACCUM_CTRL -- requirements
Module: accum_ctrl

Interface
REQ-001 Parameter N, default 8, operand width in bits.
REQ-002 Parameter DB_CYCLES, default 4, debounce stability window in Clock cycles (hardware builds override, e.g. 1000000).
REQ-003 Parameter COUNT_MAX, default 15, maximum accumulations before halt (1..15).
REQ-004 Clock  input  1  rising-edge system clock (50 MHz on board); the block has one clock.
REQ-005 Resetn  input  1  reset, asynchronous, active-low.
REQ-006 KEYn  input  1  raw step pushbutton, active-low, asynchronous to Clock, may bounce.
REQ-007 Clr  input  1  synchronous clear request, active-high, synchronous to Clock.
REQ-008 Sub  input  1  operation select (0 add, 1 subtract), sampled in CAPTURE.
REQ-009 Din  input  N  operand, sampled in CAPTURE.
REQ-010 Ovf_in  input  1  overflow flag from accumulator datapath, valid in CHECK.
REQ-011 Acc_en  output  1  one-cycle accumulate strobe to datapath.
REQ-012 Acc_sub  output  1  registered operation select to datapath.
REQ-013 Operand  output  N  registered operand to datapath.
REQ-014 Acc_clr  output  1  clear strobe to datapath.
REQ-015 Count  output  4  completed accumulations since last clear.
REQ-016 Busy  output  1  high while an operation is in flight.
REQ-017 Err  output  1  sticky overflow error.

Function
REQ-018 KEYn SHALL pass through a two-flop synchronizer before any other use.
REQ-019 A press event SHALL be a single-cycle pulse generated when the synchronized KEYn has been low for DB_CYCLES consecutive cycles while armed.
REQ-020 The debouncer SHALL re-arm only after the synchronized KEYn has been high for DB_CYCLES consecutive cycles; one physical press yields exactly one event regardless of hold time or bounce shorter than DB_CYCLES.
REQ-021 FSM states SHALL be IDLE, CAPTURE, EXEC, CHECK, HALT.
REQ-022 IDLE -> CAPTURE on press event; press events in any other state SHALL be discarded.
REQ-023 CAPTURE SHALL load Operand<=Din and Acc_sub<=Sub, then -> EXEC.
REQ-024 EXEC SHALL drive Acc_en=1 for exactly that one cycle, then -> CHECK; Acc_en SHALL be 0 in all other states.
REQ-025 CHECK with Ovf_in=1 SHALL set Err=1, leave Count unchanged, -> HALT.
REQ-026 CHECK with Ovf_in=0 SHALL increment Count; -> HALT if the new Count equals COUNT_MAX, else -> IDLE.
REQ-027 HALT SHALL hold until Clr; Count SHALL never exceed COUNT_MAX nor wrap.
REQ-028 Latency: press event in cycle t -> CAPTURE t+1, Acc_en high t+2, Count/Err updated at end of t+3.
REQ-029 Clr SHALL have priority over all transitions: at the next edge state<=IDLE, Count<=0, Err<=0, and Acc_clr is high for the cycle following each cycle Clr is sampled high.
REQ-030 Clr sampled in CAPTURE SHALL prevent the EXEC cycle; Clr sampled in EXEC SHALL abort CHECK (Acc_en in that cycle still occurs; the following Acc_clr supersedes it).
REQ-031 Clr coincident with a press event SHALL discard the press.
REQ-032 Busy SHALL be high exactly in CAPTURE, EXEC, CHECK.
REQ-033 Operand and Acc_sub SHALL hold their values outside CAPTURE, including across Clr.

Reset
REQ-034 Resetn low SHALL immediately force state IDLE, Count=0, Err=0, Acc_en=0, Acc_clr=0, Acc_sub=0, Operand=0, Busy=0, synchronizer flops high (released), debouncer armed with counter 0.
REQ-035 Reset asserted mid-operation SHALL abort without issuing Acc_en; first press event is recognized no earlier than DB_CYCLES+2 cycles after Resetn rises.

Verification
REQ-036 Clean press, Din=8'h05, Sub=0, Ovf_in=0 -> one Acc_en pulse with Operand=8'h05, Acc_sub=0, Count 0->1, Busy high 3 cycles.
REQ-037 KEYn bouncing (low 2, high 1, low 2 cycles) then held low 20 cycles, DB_CYCLES=4 -> exactly one press event; no second event until KEYn high 4 stable cycles.
REQ-038 15 presses, Ovf_in=0 -> Count=15, state HALT; 16th press -> no Acc_en, Count stays 15; Clr -> Acc_clr one cycle, Count=0, IDLE.
REQ-039 Press with Ovf_in=1 in CHECK -> Err=1, Count unchanged, HALT; further presses ignored until Clr clears Err.
REQ-040 Clr asserted in CAPTURE cycle -> no Acc_en, Acc_clr next cycle, IDLE; Clr in EXEC cycle -> single Acc_en then Acc_clr, Count unchanged.
REQ-041 Resetn pulsed low during EXEC -> Acc_en drops asynchronously, all outputs at reset values, Count=0.
